// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling,
// valid/ready byte output with one-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic        sync1_q, rx_s_q, prev_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        div_cnt_d = div_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                div_cnt_d = 16'd0;
                // Edge, not level: a line stuck low after a framing error cannot retrigger.
                if (prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (div_cnt_q == HALF_M1) begin
                    div_cnt_d = 16'd0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (div_cnt_q == DIV_M1) begin
                    div_cnt_d          = 16'd0;
                    shift_d[bit_cnt_q] = rx_s_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (div_cnt_q == DIV_M1) begin
                    div_cnt_d = 16'd0;
                    state_d   = IDLE;
                    if (!rx_s_q) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || ready_i) begin
                        // A byte accepted in this same cycle frees the slot, so no overrun.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            div_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            rx_s_q    <= sync1_q;
            prev_q    <= rx_s_q;
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of single frames plus hand-written
// sequences for overrun, held-low framing error, start glitch, reset mid-frame and baud skew.
module tb_uart_rx;

    localparam int CLK_NS = 10;
    localparam int BIT_NS = 100;  // DIV=10 at 10 ns clock
    localparam int BIT_B  = 4340; // DIV=434 at 10 ns clock

    logic clk = 1'b0;
    logic rst_n;
    logic rx_a, ready_a;
    logic [7:0] data_a;
    logic valid_a, busy_a, ferr_a, ovr_a;
    logic rx_b;
    logic [7:0] data_b;
    logic valid_b, busy_b, ferr_b, ovr_b;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready_a), .busy_o(busy_a), .frame_err_o(ferr_a), .overrun_o(ovr_a)
    );

    uart_rx #(.CLK_HZ(50_000_000), .BAUD(115200)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(1'b1), .busy_o(busy_b), .frame_err_o(ferr_b), .overrun_o(ovr_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor sampled on the falling edge, away from the active edge.
    int rises = 0, vcyc = 0, nferr = 0, novr = 0, nbusy = 0, stab_err = 0, excl_err = 0;
    int rises_b = 0, nferr_b = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0;
    logic [7:0] pd_a = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a && !pv_a) begin rises++; last_a = data_a; end
            if (valid_a) vcyc++;
            if (ferr_a) nferr++;
            if (ovr_a) novr++;
            if (busy_a) nbusy++;
            if (ferr_a && ovr_a) excl_err++;
            if (pv_a && !pr_a && valid_a && data_a != pd_a) stab_err++;
            if (valid_b && !pv_b) begin rises_b++; last_b = data_b; end
            if (ferr_b) nferr_b++;
        end
        pv_a = valid_a; pr_a = ready_a; pd_a = data_a; pv_b = valid_b;
    end

    task automatic send_a(input logic [7:0] b, input logic stop);
        @(posedge clk); #3;
        rx_a = 1'b0; #BIT_NS;
        for (int i = 0; i < 8; i++) begin rx_a = b[i]; #BIT_NS; end
        rx_a = stop; #BIT_NS;
    endtask

    task automatic send_b(input logic [7:0] b, input int bit_ns);
        @(posedge clk); #3;
        rx_b = 1'b0; #bit_ns;
        for (int i = 0; i < 8; i++) begin rx_b = b[i]; #bit_ns; end
        rx_b = 1'b1; #bit_ns;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_rise;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs [4];
    int r0, v0, f0, o0, b0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 1};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'hFF, 1, 0};

        rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_o", data_a, 0);
        check("reset valid_o", valid_a, 0);
        check("reset busy_o", busy_a, 0);
        check("reset frame_err_o", ferr_a, 0);
        check("reset overrun_o", ovr_a, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table: single frames with the consumer always ready.
        ready_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r0 = rises; v0 = vcyc; f0 = nferr; o0 = novr;
            send_a(vecs[k].d, vecs[k].stop);
            rx_a = 1'b1;
            #(3 * BIT_NS);
            check($sformatf("vec%0d valid rises", k), rises - r0, vecs[k].exp_rise);
            check($sformatf("vec%0d data_o", k), last_a, vecs[k].exp_data);
            check($sformatf("vec%0d frame_err", k), nferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d overrun", k), novr - o0, 0);
            check($sformatf("vec%0d valid cycles", k), vcyc - v0, vecs[k].exp_vcyc);
        end

        // Overrun: two back-to-back bytes with the consumer stalled.
        ready_a = 1'b0;
        r0 = rises; f0 = nferr; o0 = novr;
        send_a(8'h00, 1'b1);
        send_a(8'hFF, 1'b1);
        rx_a = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("ovr valid held", valid_a, 1);
        check("ovr data kept", data_a, 8'h00);
        check("ovr pulse count", novr - o0, 1);
        check("ovr rises", rises - r0, 1);
        check("ovr no frame_err", nferr - f0, 0);
        @(posedge clk); #1; ready_a = 1'b1;
        @(negedge clk);
        check("accept valid still high", valid_a, 1);
        @(negedge clk);
        check("accept valid cleared", valid_a, 0);

        // Framing error followed by a line held low: no retrigger until it rises and falls.
        r0 = rises; f0 = nferr; o0 = novr;
        send_a(8'h3C, 1'b0);
        #(30 * CLK_NS);
        @(negedge clk);
        check("held low busy", busy_a, 0);
        check("held low frame_err count", nferr - f0, 1);
        check("held low valid", valid_a, 0);
        rx_a = 1'b1;
        #(2 * BIT_NS);
        send_a(8'h81, 1'b1);
        rx_a = 1'b1;
        #(2 * BIT_NS);
        check("after ferr data_o", last_a, 8'h81);
        check("after ferr rises", rises - r0, 1);
        check("after ferr no extra ferr", nferr - f0, 1);

        // Start glitch: 3 cycles low from idle.
        r0 = rises; f0 = nferr; o0 = novr; b0 = nbusy;
        @(posedge clk); #3; rx_a = 1'b0;
        #(3 * CLK_NS); rx_a = 1'b1;
        #(3 * BIT_NS);
        check("glitch busy seen", int'((nbusy - b0) > 0), 1);
        check("glitch busy short", int'((nbusy - b0) < 10), 1);
        check("glitch no valid", rises - r0, 0);
        check("glitch no ferr", nferr - f0, 0);
        check("glitch no ovr", novr - o0, 0);

        // Reset during bit 4 of 0x5A; data_o still holds 0x81 beforehand.
        r0 = rises; f0 = nferr; o0 = novr;
        @(posedge clk); #3; rx_a = 1'b0; #BIT_NS;
        for (int i = 0; i < 4; i++) begin rx_a = 1'(8'h5A >> i); #BIT_NS; end
        rx_a = 1'b0; #(BIT_NS / 2);
        check("pre-reset busy", busy_a, 1);
        rst_n = 1'b0; #1;
        check("midframe reset busy", busy_a, 0);
        check("midframe reset data_o", data_a, 0);
        check("midframe reset valid", valid_a, 0);
        rx_a = 1'b1; #(BIT_NS);
        @(posedge clk); #3; rst_n = 1'b1;
        #(2 * BIT_NS);
        send_a(8'h5A, 1'b1);
        rx_a = 1'b1;
        #(2 * BIT_NS);
        check("post-reset data_o", last_a, 8'h5A);
        check("post-reset rises", rises - r0, 1);
        check("post-reset no pulses", (nferr - f0) + (novr - o0), 0);

        // Real divider with +/-2% skew on the line.
        r0 = rises_b;
        send_b(8'h55, BIT_B * 102 / 100);
        #(2 * BIT_B);
        check("skew +2% data", last_b, 8'h55);
        send_b(8'hAA, BIT_B * 98 / 100);
        #(2 * BIT_B);
        check("skew -2% data", last_b, 8'hAA);
        check("skew rises", rises_b - r0, 2);
        check("skew no ferr", nferr_b, 0);

        check("data stable while valid", stab_err, 0);
        check("ferr/ovr exclusive", excl_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
